// File: rtl/game_state_tx.sv
// Serial transmitter for one Pong game-state snapshot: sync byte, six payload
// bytes and an XOR checksum, sent as 8N1 UART frames, LSB first.
module game_state_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        send,
    input  logic [10:0] ball_x,
    input  logic [10:0] ball_y,
    input  logic [10:0] p1_y,
    input  logic [10:0] p2_y,
    output logic        tx,
    output logic        ready,
    output logic        busy,
    output logic        done
);

    localparam int            TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [47:0]   payload_q, payload_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [7:0]    checksum;
    logic [7:0]    cur_byte;
    logic [2:0]    next_bit;

    assign checksum = payload_q[7:0]   ^ payload_q[15:8]  ^ payload_q[23:16] ^
                      payload_q[31:24] ^ payload_q[39:32] ^ payload_q[47:40];
    assign next_bit = bit_idx_q + 3'd1;

    // Frame byte 0 is the sync marker, 1..6 are payload bytes 0..5, 7 is the checksum.
    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_idx_q)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = payload_q[7:0];
            3'd2:    cur_byte = payload_q[15:8];
            3'd3:    cur_byte = payload_q[23:16];
            3'd4:    cur_byte = payload_q[31:24];
            3'd5:    cur_byte = payload_q[39:32];
            3'd6:    cur_byte = payload_q[47:40];
            default: cur_byte = checksum;
        endcase
    end

    // tx_d is the level for the cycle that follows the edge, keeping tx a pure flop output.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        payload_d  = payload_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (send && ready_q) begin
                    payload_d  = {4'b0, p2_y, p1_y, ball_y, ball_x};
                    state_d    = S_START;
                    timer_d    = '0;
                    bit_idx_d  = 3'd0;
                    byte_idx_d = 3'd0;
                    tx_d       = 1'b0;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_START: begin
                if (timer_q == BIT_LAST) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                    tx_d      = cur_byte[0];
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = next_bit;
                        tx_d      = cur_byte[next_bit];
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (byte_idx_q != 3'd7) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = S_START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 3'd0;
            payload_q  <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            payload_q  <= payload_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
